// File: rtl/poly_key_tone_gen_pkg.sv
// Note table and shared widths for the polyphonic-key tone generator.
// Half-periods are in 1 MHz clock cycles for C4..C5.
package simplepiano_pkg;

  localparam int NOTE_IDX_W = 3;
  localparam int VOL_W      = 3;
  localparam int OCT_W      = 2;

  localparam logic [11:0] NOTE_HALF_PERIOD [0:7] = '{
    12'd1911, 12'd1703, 12'd1517, 12'd1432,
    12'd1276, 12'd1136, 12'd1012, 12'd956
  };

  // Each octave step halves the half-period; 956 >> 3 = 119 keeps it nonzero.
  function automatic logic [11:0] half_period(input logic [NOTE_IDX_W-1:0] idx,
                                              input logic [OCT_W-1:0]      oct);
    return NOTE_HALF_PERIOD[idx] >> oct;
  endfunction

endpackage

// File: rtl/poly_key_tone_gen_key_debounce.sv
// One key: 2-flop synchroniser followed by a stable-run counter that only
// accepts a new level after DEBOUNCE_CYCLES consecutive matching samples.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int DEBOUNCE_W      = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic key_level
);

  logic                  sync1_q, sync2_q;
  logic                  level_q, level_d;
  logic [DEBOUNCE_W-1:0] cnt_q, cnt_d;

  // Counter only runs while the synchronised level disagrees with the
  // accepted level, so any bounce back drops it to zero.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == DEBOUNCE_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign key_level = level_q;

endmodule

// File: rtl/poly_key_tone_gen.sv
// Debounced key bank -> fixed-priority note select -> glitch-free square wave
// with octave shift and a 3-bit PWM volume gate.
module poly_key_tone_gen
  import simplepiano_pkg::*;
#(
  parameter int NUM_KEYS        = 8,
  parameter int WIDTH_COUNTER   = 12,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int DEBOUNCE_W      = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_KEYS-1:0]   keys,
  input  logic [OCT_W-1:0]      octave,
  input  logic [VOL_W-1:0]      volume,
  output logic                  tone_out,
  output logic                  tone_raw,
  output logic                  active,
  output logic [NOTE_IDX_W-1:0] note_idx
);

  logic [NUM_KEYS-1:0] deb_keys;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .DEBOUNCE_W     (DEBOUNCE_W)
    ) u_key_debounce (
      .clk      (clk),
      .rst_n    (rst_n),
      .key_raw  (keys[k]),
      .key_level(deb_keys[k])
    );
  end

  logic                     active_q, active_d;
  logic [NOTE_IDX_W-1:0]    note_idx_q, note_idx_d;
  logic [WIDTH_COUNTER-1:0] cnt_q, cnt_d;
  logic [WIDTH_COUNTER-1:0] period_q, period_d;
  logic                     tone_raw_q, tone_raw_d;
  logic [VOL_W-1:0]         pwm_q, pwm_d;
  logic                     tone_out_q, tone_out_d;

  always_comb begin
    active_d   = |deb_keys;
    note_idx_d = note_idx_q;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (deb_keys[k]) note_idx_d = NOTE_IDX_W'(k);
    end
  end

  // The period only reloads at a toggle, so mid half-cycle note or octave
  // changes never shorten the half-cycle in flight. Gate start uses the
  // incoming selection because the registered one is still stale then.
  always_comb begin
    cnt_d      = cnt_q;
    period_d   = period_q;
    tone_raw_d = tone_raw_q;
    if (!active_d) begin
      cnt_d      = '0;
      tone_raw_d = 1'b0;
    end else if (!active_q) begin
      cnt_d      = '0;
      tone_raw_d = 1'b1;
      period_d   = WIDTH_COUNTER'(half_period(note_idx_d, octave));
    end else if (cnt_q == period_q - 1'b1) begin
      cnt_d      = '0;
      tone_raw_d = ~tone_raw_q;
      period_d   = WIDTH_COUNTER'(half_period(note_idx_q, octave));
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    pwm_d      = pwm_q + 1'b1;
    tone_out_d = tone_raw_d & ((volume == 3'd7) | (pwm_d < volume));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q   <= 1'b0;
      note_idx_q <= '0;
      cnt_q      <= '0;
      period_q   <= '0;
      tone_raw_q <= 1'b0;
      pwm_q      <= '0;
      tone_out_q <= 1'b0;
    end else begin
      active_q   <= active_d;
      note_idx_q <= note_idx_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      tone_raw_q <= tone_raw_d;
      pwm_q      <= pwm_d;
      tone_out_q <= tone_out_d;
    end
  end

  assign tone_out = tone_out_q;
  assign tone_raw = tone_raw_q;
  assign active   = active_q;
  assign note_idx = note_idx_q;

endmodule

// File: tb/tb_poly_key_tone_gen.sv
// Bench for poly_key_tone_gen: timestamp-based reference model feeding an
// expected-output queue, drained by a free-running monitor.
module tb_poly_key_tone_gen;

  localparam int NKEYS = 8;
  localparam int DEB   = 1000;
  localparam int HP [0:7] = '{1911, 1703, 1517, 1432, 1276, 1136, 1012, 956};

  logic             clk    = 1'b0;
  logic             rst_n  = 1'b0;
  logic [NKEYS-1:0] keys   = '0;
  logic [1:0]       octave = '0;
  logic [2:0]       volume = 3'd7;
  logic             tone_out, tone_raw, active;
  logic [2:0]       note_idx;

  poly_key_tone_gen #(
    .NUM_KEYS       (NKEYS),
    .WIDTH_COUNTER  (12),
    .DEBOUNCE_CYCLES(DEB),
    .DEBOUNCE_W     (10)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .keys    (keys),
    .octave  (octave),
    .volume  (volume),
    .tone_out(tone_out),
    .tone_raw(tone_raw),
    .active  (active),
    .note_idx(note_idx)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int         vectors     = 0;
  int         miscompares = 0;
  logic [5:0] exp_q[$];

  // ---------------- reference model ----------------
  // Time-stamped view: a key's accepted level flips once its synchronised
  // level has been unchanged for DEB edges; the tone tracks elapsed edges.
  int         m_t;
  logic [7:0] m_r1, m_r2, m_prev_s, m_deb, m_s;
  int         m_since[NKEYS];
  logic       m_active, m_tone, m_gate, n_active;
  logic [2:0] m_idx, n_idx;
  int         m_per, m_elapsed;

  function automatic int hp(input int idx, input int oct);
    return HP[idx] >> oct;
  endfunction

  task automatic model_reset();
    m_t = 0; m_r1 = '0; m_r2 = '0; m_prev_s = '0; m_deb = '0;
    for (int k = 0; k < NKEYS; k++) m_since[k] = 0;
    m_active = 1'b0; m_tone = 1'b0; m_idx = '0; m_per = 0; m_elapsed = 0;
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      model_reset();
      exp_q.push_back('0);
    end else begin
      m_t++;
      m_s  = m_r2;
      m_r2 = m_r1;
      m_r1 = keys;
      n_active = (m_deb != 0);
      n_idx    = m_idx;
      for (int k = NKEYS - 1; k >= 0; k--) if (m_deb[k]) n_idx = 3'(k);
      for (int k = 0; k < NKEYS; k++) begin
        if (m_s[k] != m_prev_s[k]) begin
          m_prev_s[k] = m_s[k];
          m_since[k]  = m_t;
        end
        if (m_s[k] != m_deb[k] && (m_t - m_since[k] + 1) >= DEB) m_deb[k] = m_s[k];
      end
      if (!n_active) begin
        m_tone = 1'b0;
      end else if (!m_active) begin
        m_tone = 1'b1; m_per = hp(int'(n_idx), int'(octave)); m_elapsed = 0;
      end else begin
        m_elapsed++;
        if (m_elapsed == m_per) begin
          m_tone = ~m_tone; m_elapsed = 0; m_per = hp(int'(m_idx), int'(octave));
        end
      end
      m_active = n_active;
      m_idx    = n_idx;
      m_gate   = (volume == 3'd7) || ((m_t % 8) < int'(volume));
      exp_q.push_back({m_tone & m_gate, m_tone, m_active, m_idx});
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [5:0] mon_exp, mon_act;
  initial begin
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      mon_act = {tone_out, tone_raw, active, note_idx};
      if (clk) begin
        // woken by an asynchronous reset between edges
        vectors++;
        if (mon_act !== 6'd0) begin
          miscompares++;
          $display("FAIL async_reset t=%0t got=%b exp=000000", $time, mon_act);
        end
      end else if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        if (!rst_n) mon_exp = '0;
        vectors++;
        if (mon_act !== mon_exp) begin
          miscompares++;
          $display("FAIL cycle_out t=%0t {out,raw,act,idx} got=%b exp=%b",
                   $time, mon_act, mon_exp);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic bounce_key(input int k, input int toggles);
    for (int i = 0; i < toggles; i++) begin
      keys[k] = ~keys[k];
      step($urandom_range(5, 300));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset with key 0 held: tone appears 1003 edges after release.
    keys = 8'h01; octave = 2'd0; volume = 3'd7;
    step(3);
    rst_n = 1'b1;
    step(1003 + 4 * 1911 + 50);

    // Two keys, lowest wins; releasing it mid half-cycle defers the new pitch.
    keys = 8'h28;
    step(DEB + 700);
    keys = 8'h20;
    step(DEB + 3 * 1432);

    // Release everything, then bounce key 2 before it settles high.
    keys = 8'h00;
    step(DEB + 200);
    for (int i = 0; i < 7; i++) begin
      keys[2] = ~keys[2];
      step(400);
    end
    keys[2] = 1'b1;
    step(DEB + 1500);

    // Highest key, top octave; drop the octave mid half-cycle.
    keys = 8'h80; octave = 2'd3;
    step(DEB + 300);
    step(60);
    octave = 2'd0;
    step(3 * 956);

    // PWM levels.
    volume = 3'd3;
    step(2000);
    volume = 3'd0;
    step(2000);
    volume = 3'd7;
    step(500);

    // Reset mid-note with the key still held, then a normal release.
    #1;
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(DEB + 1200);
    keys = 8'h00;
    step(DEB + 100);

    // Randomised segments: key sets, octave, volume, bounces.
    for (int seg = 0; seg < 10; seg++) begin
      keys   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      octave = 2'($urandom_range(0, 3));
      volume = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) bounce_key($urandom_range(0, NKEYS - 1), $urandom_range(2, 6));
      step($urandom_range(1200, 2500));
      octave = 2'($urandom_range(0, 3));
      step($urandom_range(200, 1500));
    end

    step(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/poly_key_tone_gen.md
Name: poly_key_tone_gen

Overview:
Parametrised successor to the single fixed-pitch tone generator. It takes NUM_KEYS piano keys, synchronises and debounces them, picks one note by fixed priority, applies an octave shift, and produces a square-wave tone with a 3-bit PWM volume gate. The tone has glitch-free pitch changes. It sits directly under the TT top; its tone output drives uo_out[0] and its status drives the remaining uo_out bits.

Parameters:
NUM_KEYS, 8, number of key inputs (1..8; index 0 = C4 … index 7 = C5)
WIDTH_COUNTER, 12, tone counter width; must hold the largest table entry
DEBOUNCE_CYCLES, 1000, consecutive stable samples required to accept a key level
DEBOUNCE_W, 10, debounce counter width (2^DEBOUNCE_W > DEBOUNCE_CYCLES)

Ports:
clk  in  1  system clock (1 MHz nominal; the note table assumes it)
rst_n  in  1  asynchronous active-low reset
keys  in  NUM_KEYS  raw key levels, active high, asynchronous
octave  in  2  right-shift applied to the half-period (0 = base octave, 3 = +3 octaves)
volume  in  3  PWM level: 0 mute, 1..6 = n/8 duty, 7 continuous
tone_out  out  1  gated square wave
tone_raw  out  1  ungated square wave
active  out  1  a note is sounding
note_idx  out  3  index of the selected key

Behaviour:
- Reset (asynchronous, rst_n low): all outputs 0; all counters, synchronisers and debounced states 0.
- Synchronisation:
  - Each key passes through a 2-flop synchroniser, then key_debounce.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive cycles of the new synchronised level.
  - Any bounce restarts the count.
- Selection (1 registered stage after the debounced vector):
  - The lowest-index pressed key wins; active = OR of debounced keys.
  - When no key is pressed, note_idx holds its last value.
- Half-period:
  - target = NOTE_HALF_PERIOD[note_idx] >> octave, computed combinationally from the registered selection.
  - octave is sampled only when a new period is latched.
- Tone counter:
  - Gate start (active 0→1): cnt←0, tone_raw←1, latch target, in the same cycle that active rises.
  - While active: if cnt == period−1, then tone_raw toggles, cnt←0, and period←target (the latch point). Otherwise cnt←cnt+1.
  - Result: a note or octave change mid half-cycle takes effect only at the next toggle, so there are no runt pulses.
  - Gate end (active 1→0): tone_raw←0 and cnt←0 in the same cycle; the half-cycle is not completed.
- PWM:
  - 3-bit free-running pwm_cnt (reset 0).
  - tone_out = tone_raw & (volume==7 | pwm_cnt < volume).
  - A volume change applies on the next cycle.
- Boundaries:
  - Simultaneous press of several keys → lowest index.
  - Releasing the winning key while others are held → active stays 1; the new note is applied at the next toggle.
  - Smallest period = 956>>3 = 119, so the period never reaches 0.
  - Reset mid-note → immediate silence; the debouncers restart from 0, so held keys re-sound after DEBOUNCE_CYCLES + 3 cycles.
- Latency:
  - Raw key edge → active = 2 (sync) + DEBOUNCE_CYCLES + 1 (select) cycles, i.e. 1003 at default.

Decomposition:
- Package simplepiano_pkg:
  - NOTE_HALF_PERIOD[0:7] = 1911, 1703, 1517, 1432, 1276, 1136, 1012, 956.
  - Constants NOTE_IDX_W = 3, VOL_W = 3, OCT_W = 2.
- Sub-module key_debounce (parameters DEBOUNCE_CYCLES, DEBOUNCE_W):
  - Contains the synchroniser, the stable counter and the debounced level register.
  - Instantiated NUM_KEYS times via generate.

Test Plan:
- Reset with keys=8'h01 held, octave=0, volume=7 → active rises 1003 cycles after release of reset. tone_raw is high for 1911 cycles, low for 1911, repeating. tone_out == tone_raw.
- keys=8'h28 (keys 3 and 5) → note_idx=3, half-period 1432. Release key 3 mid half-cycle → note_idx=5 after debounce. The current half-cycle still ends at 1432 cycles; the next half-cycles are 1136.
- Bounce on key 2 (toggle every 400 cycles for 3000 cycles, then stable high) → active stays 0 until 1003 cycles after the last edge. There is no tone before that.
- keys=8'h80, octave=3 → half-period 119. Change octave to 0 mid half-cycle → the current half-cycle stays 119 and the next is 956.
- Sounding note, volume=3 → within each 8-cycle PWM window where tone_raw=1, tone_out is high exactly 3 cycles. volume=0 → tone_out constantly 0 while tone_raw toggles.
- Assert rst_n low mid-note → all outputs 0 in the same cycle (async). Release all keys normally → tone_raw and cnt clear in the cycle active falls.
